// File: rtl/elevator_car_controller.sv
// Elevator car controller: accepts one floor request at a time while idle,
// travels one floor per TRAVEL_CYCLES clocks, then holds the door open for
// DOOR_CYCLES clocks before accepting the next request.
module elevator_car_controller #(
    parameter logic [3:0]  BOTTOM        = 4'd1,
    parameter logic [3:0]  TOP           = 4'd10,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    output logic [3:0] location,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrived,
    output logic       err
);

    // Timers count down to zero, so they load with the cycle count minus one.
    localparam logic [3:0] TRAVEL_RELOAD = 4'(TRAVEL_CYCLES - 1);
    localparam logic [3:0] DOOR_RELOAD   = 4'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] goal;
    logic [3:0] travel_timer;
    logic [3:0] door_timer;

    logic       accept;
    logic       in_range;
    logic [3:0] next_floor;

    // Handshake and request classification for the idle state.
    assign accept   = target_valid & target_ready;
    assign in_range = (target >= BOTTOM) && (target <= TOP);

    // Floor reached by the next step; goal is always in range, so the car
    // stops before this could wrap or leave [BOTTOM, TOP].
    assign next_floor = dir_up ? (location + 4'd1) : (location - 4'd1);

    // Car FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            goal         <= BOTTOM;
            travel_timer <= 4'd0;
            door_timer   <= 4'd0;
            location     <= BOTTOM;
            target_ready <= 1'b1;
            moving       <= 1'b0;
            dir_up       <= 1'b0;
            door_open    <= 1'b0;
            arrived      <= 1'b0;
            err          <= 1'b0;
        end else begin
            arrived <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            err <= 1'b1;
                        end else if (target == location) begin
                            goal         <= target;
                            state        <= DOOR;
                            target_ready <= 1'b0;
                            door_open    <= 1'b1;
                            door_timer   <= DOOR_RELOAD;
                            arrived      <= 1'b1;
                        end else begin
                            goal         <= target;
                            state        <= MOVING;
                            target_ready <= 1'b0;
                            moving       <= 1'b1;
                            dir_up       <= (target > location);
                            travel_timer <= TRAVEL_RELOAD;
                        end
                    end
                end

                MOVING: begin
                    if (travel_timer == 4'd0) begin
                        location     <= next_floor;
                        travel_timer <= TRAVEL_RELOAD;
                        if (next_floor == goal) begin
                            state      <= DOOR;
                            moving     <= 1'b0;
                            dir_up     <= 1'b0;
                            door_open  <= 1'b1;
                            door_timer <= DOOR_RELOAD;
                            arrived    <= 1'b1;
                        end
                    end else begin
                        travel_timer <= travel_timer - 4'd1;
                    end
                end

                DOOR: begin
                    if (door_timer == 4'd0) begin
                        state        <= IDLE;
                        door_open    <= 1'b0;
                        target_ready <= 1'b1;
                    end else begin
                        door_timer <= door_timer - 4'd1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    target_ready <= 1'b1;
                    moving       <= 1'b0;
                    dir_up       <= 1'b0;
                    door_open    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: a reset/error/same-floor vector table
// followed by full trips (up, down, same floor, aborted by reset).
module tb_elevator_car_controller;

    localparam int T  = 4;
    localparam int DC = 3;

    typedef struct packed {
        logic       ready;
        logic [3:0] loc;
        logic       moving;
        logic       dir_up;
        logic       door_open;
        logic       arrived;
        logic       err;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] tg;
        logic       v;
        exp_t       e;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] target;
    logic       target_valid;
    logic       target_ready;
    logic [3:0] location;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       arrived;
    logic       err;

    int checks   = 0;
    int failures = 0;

    exp_t  sb_q[$];
    string nm_q[$];

    elevator_car_controller dut (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .location     (location),
        .moving       (moving),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .arrived      (arrived),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic r, input logic [3:0] l, input logic m,
                                input logic d, input logic o, input logic a, input logic e);
        exp_t x;
        x.ready = r; x.loc = l; x.moving = m; x.dir_up = d;
        x.door_open = o; x.arrived = a; x.err = e;
        return x;
    endfunction

    function automatic exp_t idle(input logic [3:0] l);
        return mk(1'b1, l, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic compare_out();
        exp_t  e;
        exp_t  act;
        string nm;
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        act = mk(target_ready, location, moving, dir_up, door_open, arrived, err);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got rdy=%0b loc=%0d mov=%0b up=%0b door=%0b arr=%0b err=%0b, expected rdy=%0b loc=%0d mov=%0b up=%0b door=%0b arr=%0b err=%0b",
                     nm, act.ready, act.loc, act.moving, act.dir_up, act.door_open, act.arrived, act.err,
                     e.ready, e.loc, e.moving, e.dir_up, e.door_open, e.arrived, e.err);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic [3:0] tg, input logic v,
                       input exp_t e, input string nm);
        reset        = r;
        target       = tg;
        target_valid = v;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Accept 'to' from 'from', then walk the trip with junk on the inputs.
    // Expected floor after t cycles is from +/- floor(t/T); abort_at > 0
    // asserts reset on that cycle instead.
    task automatic trip(input logic [3:0] from, input logic [3:0] to, input int abort_at);
        int         d;
        int         arr;
        bit         up;
        exp_t       e;
        logic [3:0] loc;
        up  = (to > from);
        d   = up ? int'(to) - int'(from) : int'(from) - int'(to);
        arr = d * T;
        for (int t = 0; t <= arr + DC; t++) begin
            if (abort_at != 0 && t == abort_at) begin
                cyc(1'b1, 4'd7, 1'b1, idle(4'd1), $sformatf("abort %0d->%0d reset", from, to));
                cyc(1'b0, 4'd0, 1'b0, idle(4'd1), $sformatf("abort %0d->%0d idle", from, to));
                return;
            end
            if (t == arr)
                e = mk(1'b0, to, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            else if (t < arr) begin
                loc = up ? 4'(int'(from) + t / T) : 4'(int'(from) - t / T);
                e = mk(1'b0, loc, 1'b1, up, 1'b0, 1'b0, 1'b0);
            end else if (t < arr + DC)
                e = mk(1'b0, to, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else
                e = idle(to);
            if (t == 0)
                cyc(1'b0, to, 1'b1, e, $sformatf("trip %0d->%0d accept", from, to));
            else
                cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), e,
                    $sformatf("trip %0d->%0d t=%0d", from, to, t));
        end
    endtask

    vec_t vecs[12];

    initial begin
        reset        = 1'b1;
        target       = 4'd0;
        target_valid = 1'b0;

        vecs[0]  = '{1'b1, 4'd0,  1'b0, idle(4'd1), "reset"};
        vecs[1]  = '{1'b1, 4'd5,  1'b1, idle(4'd1), "reset beats accept"};
        vecs[2]  = '{1'b0, 4'd7,  1'b0, idle(4'd1), "idle no valid"};
        vecs[3]  = '{1'b0, 4'd0,  1'b1, mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "err target 0"};
        vecs[4]  = '{1'b0, 4'd3,  1'b0, idle(4'd1), "err clears"};
        vecs[5]  = '{1'b0, 4'd11, 1'b1, mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "err target 11"};
        vecs[6]  = '{1'b0, 4'd15, 1'b1, mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "err target 15"};
        vecs[7]  = '{1'b0, 4'd1,  1'b1, mk(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "same floor accept"};
        vecs[8]  = '{1'b0, 4'd5,  1'b1, mk(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "door cycle 2"};
        vecs[9]  = '{1'b0, 4'd5,  1'b1, mk(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "door cycle 3"};
        vecs[10] = '{1'b0, 4'd5,  1'b1, idle(4'd1), "door closes"};
        vecs[11] = '{1'b0, 4'd5,  1'b0, idle(4'd1), "no late accept"};

        foreach (vecs[i])
            cyc(vecs[i].rst, vecs[i].tg, vecs[i].v, vecs[i].e, vecs[i].name);

        trip(4'd1,  4'd4,  0);
        trip(4'd4,  4'd4,  0);
        trip(4'd4,  4'd10, 0);
        trip(4'd10, 4'd1,  0);
        trip(4'd1,  4'd4,  6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_car_controller.md
ELEVATOR_CAR_CONTROLLER -- requirements
Module: elevator_car_controller

Interface
REQ-001 Parameter BOTTOM, default 4'd1, lowest served floor.
REQ-002 Parameter TOP, default 4'd10, highest served floor.
REQ-003 Parameter TRAVEL_CYCLES, default 4, clock cycles per one-floor move (legal range 1..15).
REQ-004 Parameter DOOR_CYCLES, default 3, clock cycles the door stays open (legal range 1..15).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 target  input  4  requested floor, e.g. the idle floor from the closest-idle calculator or a call request.
REQ-008 target_valid  input  1  target is presented this cycle.
REQ-009 target_ready  output  1  controller accepts a target this cycle.
REQ-010 location  output  4  current car floor; feeds the closest-idle calculator.
REQ-011 moving  output  1  car is travelling between floors.
REQ-012 dir_up  output  1  1 = travelling up, 0 = down or stationary.
REQ-013 door_open  output  1  door is open.
REQ-014 arrived  output  1  one-cycle pulse on arrival at the accepted target.
REQ-015 err  output  1  one-cycle pulse when an out-of-range target is accepted.

Function
REQ-016 FSM states SHALL be IDLE, MOVING, DOOR; there are no other reachable states.
REQ-017 target_ready SHALL be 1 only in IDLE; target_valid SHALL be ignored in MOVING and DOOR.
REQ-018 Accept SHALL occur on an edge where target_valid & target_ready; target SHALL be latched internally at that edge, and later changes to the target input SHALL have no effect.
REQ-019 Accepted target < BOTTOM or > TOP SHALL pulse err for the cycle after acceptance and keep the FSM in IDLE; location SHALL be unchanged.
REQ-020 Accepted target == location SHALL go IDLE->DOOR with no movement and pulse arrived for the cycle after acceptance.
REQ-021 Accepted in-range target != location SHALL go IDLE->MOVING, load the travel timer with TRAVEL_CYCLES-1, and set dir_up = (target > location).
REQ-022 In MOVING, the timer SHALL decrement every cycle; when the timer is 0, location SHALL step by +1 (dir_up) or -1 and the timer SHALL reload.
REQ-023 For a distance of d floors accepted at edge k, location SHALL change at edges k+TRAVEL_CYCLES, k+2*TRAVEL_CYCLES, ... and reach the target at edge k+d*TRAVEL_CYCLES.
REQ-024 On the edge where the step makes location equal the latched target, the FSM SHALL go to DOOR, moving and dir_up SHALL go to 0, and arrived SHALL be 1 for exactly the following cycle.
REQ-025 location SHALL never leave [BOTTOM, TOP]; arithmetic SHALL be 4-bit unsigned with no wrap-around reachable.
REQ-026 In DOOR, door_open SHALL be 1 for exactly DOOR_CYCLES cycles, then the FSM SHALL return to IDLE with target_ready = 1.
REQ-027 In IDLE, moving = 0, door_open = 0 and dir_up = 0.
REQ-028 err and arrived SHALL never both be 1 in the same cycle.

Reset
REQ-029 While reset = 1 at a posedge, the block SHALL go to IDLE with location = BOTTOM, moving = 0, dir_up = 0, door_open = 0, arrived = 0, err = 0, target_ready = 1, and the timers cleared.
REQ-030 Reset SHALL take priority over every other event, including an acceptance or a step on the same edge, and SHALL abort a move or door cycle in progress.

Verification (defaults)
REQ-031 Reset -> location = 1, target_ready = 1, all other outputs 0 from the next cycle.
REQ-032 From location 1, accept target 4 at edge k -> location = 2/3/4 at k+4/k+8/k+12, dir_up = 1 while moving, arrived high for one cycle after k+12, door_open high for 3 cycles, then target_ready = 1.
REQ-033 From location 10, accept target 1 -> 9 steps down, dir_up = 0 throughout, arrival at k+36.
REQ-034 Accept target equal to location (e.g. 4 at location 4) -> no location change, arrived pulse, door_open high for 3 cycles.
REQ-035 Accept target 0 or 11 -> err pulses for one cycle, FSM stays in IDLE, location unchanged; target_valid toggled while MOVING -> no effect on the trip.
REQ-036 Assert reset at k+6 during the 1->4 trip -> location = 1, FSM in IDLE, moving = 0 on the next cycle.
